// File: rtl/cat_ctrl_pkg.sv
// Shared types and constants for the cat FSM single-step controller.
// State encoding, bus widths and the idle input vector.
package cat_ctrl_pkg;

  localparam int XW = 11;
  localparam int YW = 22;
  localparam logic [XW-1:0] IDLE_VEC = '0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STEP,
    RESP,
    FLUSH
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; remembers the last winner so that a
// tie goes to the other requester. Requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= 1'b1;
    else if (upd)
      last <= gnt[1];
  end

endmodule

// File: rtl/cat_step_arbiter.sv
// Single-step controller for the cat FSM: arbitrates two requesters,
// applies one vector, captures the Mealy output, then clocks one step.
module cat_step_arbiter #(
  parameter int NREQ = 2,
  parameter int XW   = cat_ctrl_pkg::XW,
  parameter int YW   = cat_ctrl_pkg::YW,
  parameter int CW   = 16,
  parameter logic [XW-1:0] IDLE_VEC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*XW-1:0] req_vec,
  output logic [NREQ-1:0]  req_ready,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [YW-1:0]    resp_y,
  input  logic             resp_ready,
  input  logic             cfg_flush,
  output logic [XW-1:0]    dut_x,
  input  logic [YW-1:0]    dut_y,
  output logic             dut_clk_en,
  output logic             dut_rst,
  output logic [CW-1:0]    step_cnt
);

  import cat_ctrl_pkg::*;

  state_t state, nstate;
  logic [1:0] gnt;
  logic accept;
  logic gid;
  logic [XW-1:0] gvec;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .upd (accept),
    .gnt (gnt)
  );

  assign gid  = gnt[1];
  assign gvec = gid ? req_vec[2*XW-1:XW]
                    : req_vec[XW-1:0];

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !cfg_flush)
      req_ready = gnt;
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (cfg_flush)
          nstate = FLUSH;
        else if (accept)
          nstate = SETUP;
      end
      SETUP: nstate = STEP;
      STEP:  nstate = RESP;
      RESP:  if (resp_ready) nstate = IDLE;
      FLUSH: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // DUT-side controls are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dut_x      <= IDLE_VEC;
      dut_clk_en <= 1'b0;
      dut_rst    <= 1'b1;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_y     <= '0;
      step_cnt   <= '0;
    end else begin
      state      <= nstate;
      dut_clk_en <= (nstate == STEP);
      dut_rst    <= (nstate == FLUSH);
      unique case (state)
        IDLE: begin
          if (accept) begin
            dut_x   <= gvec;
            resp_id <= gid;
          end
        end
        SETUP: resp_y <= dut_y;
        STEP: begin
          dut_x      <= IDLE_VEC;
          resp_valid <= 1'b1;
          if (!(&step_cnt))
            step_cnt <= step_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        FLUSH: step_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cat_step_arbiter.sv
// Directed + randomized bench for cat_step_arbiter with a stand-in
// cat FSM and a transaction-level reference model.
module tb_cat_step_arbiter;

  localparam int XW = 11;
  localparam int YW = 22;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid;
  logic [2*XW-1:0] req_vec;
  logic [1:0] req_ready;
  logic resp_valid;
  logic resp_id;
  logic [YW-1:0] resp_y;
  logic resp_ready;
  logic cfg_flush;
  logic [XW-1:0] dut_x;
  logic [YW-1:0] dut_y;
  logic dut_clk_en;
  logic dut_rst;
  logic [CW-1:0] step_cnt;

  int vectors = 0;
  int miscompares = 0;

  // reference model state (transaction level)
  int model_s = 0;
  int model_cnt = 0;
  int model_total = 0;
  logic rr_last = 1'b1;

  // stand-in FSM environment
  int fsm_s = 0;
  int en_cnt = 0;

  always #5 clk = ~clk;

  cat_step_arbiter #(.CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_vec    (req_vec),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .resp_ready (resp_ready),
    .cfg_flush  (cfg_flush),
    .dut_x      (dut_x),
    .dut_y      (dut_y),
    .dut_clk_en (dut_clk_en),
    .dut_rst    (dut_rst),
    .step_cnt   (step_cnt)
  );

  function automatic logic [YW-1:0] fy(input int s, input logic [XW-1:0] x);
    logic [XW-1:0] sv;
    sv = s[XW-1:0];
    if (s == 0 && x == 11'h600)
      return 22'h000A02;
    return {sv, x} ^ 22'h15A5A5;
  endfunction

  assign dut_y = fy(fsm_s, dut_x);

  always @(posedge clk) begin
    if (dut_rst)
      fsm_s <= 0;
    else if (dut_clk_en)
      fsm_s <= fsm_s + 1;
  end

  always @(negedge clk)
    if (dut_clk_en) en_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [1:0] v, input logic [XW-1:0] v0,
                     input logic [XW-1:0] v1, input int hold);
    logic g;
    logic [XW-1:0] vg;
    logic [YW-1:0] ey;
    g  = (v == 2'b11) ? ~rr_last : v[1];
    vg = g ? v1 : v0;
    req_valid = v;
    req_vec   = {v1, v0};
    #1;
    check("grant", 32'(req_ready), g ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    rr_last   = g;
    req_valid = 2'b00;
    check("setup_x", 32'(dut_x), 32'(vg));
    check("setup_id", 32'(resp_id), 32'(g));
    check("setup_en", 32'(dut_clk_en), 0);
    check("setup_rv", 32'(resp_valid), 0);
    check("setup_rdy", 32'(req_ready), 0);
    ey = fy(model_s, vg);
    @(posedge clk); #1;
    check("step_y", 32'(resp_y), 32'(ey));
    check("step_en", 32'(dut_clk_en), 1);
    check("step_x", 32'(dut_x), 32'(vg));
    model_s++;
    model_total++;
    if (model_cnt < 15) model_cnt++;
    @(posedge clk); #1;
    check("resp_rv", 32'(resp_valid), 1);
    check("resp_x", 32'(dut_x), 0);
    check("resp_en", 32'(dut_clk_en), 0);
    check("resp_cnt", 32'(step_cnt), 32'(model_cnt));
    for (int i = 0; i < hold; i++) begin
      req_valid = 2'b11;
      @(posedge clk); #1;
      check("bp_rv", 32'(resp_valid), 1);
      check("bp_y", 32'(resp_y), 32'(ey));
      check("bp_id", 32'(resp_id), 32'(g));
      check("bp_rdy", 32'(req_ready), 0);
      check("bp_en", 32'(dut_clk_en), 0);
      check("bp_fsm", 32'(fsm_s), 32'(model_s));
    end
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("done_rv", 32'(resp_valid), 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_vec = '0;
    resp_ready = 1'b0;
    cfg_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rv", 32'(resp_valid), 0);
    check("rst_id", 32'(resp_id), 0);
    check("rst_y", 32'(resp_y), 0);
    check("rst_cnt", 32'(step_cnt), 0);
    check("rst_x", 32'(dut_x), 0);
    check("rst_en", 32'(dut_clk_en), 0);
    check("rst_drst", 32'(dut_rst), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_drst", 32'(dut_rst), 0);

    // single step with x11=x10=1 from s1
    txn(2'b01, 11'h600, 11'h000, 0);
    check("single_y", 32'(resp_y), 32'h000A02);
    check("single_cnt", 32'(step_cnt), 1);

    // contention: both valid, grants alternate
    for (int i = 0; i < 4; i++)
      txn(2'b11, 11'($urandom_range(0, 2047)),
          11'($urandom_range(0, 2047)), 0);

    // backpressure
    txn(2'b10, 11'h0, 11'($urandom_range(0, 2047)), 5);

    // flush while req0 valid
    cfg_flush = 1'b1;
    req_valid = 2'b01;
    req_vec = {11'h0, 11'h155};
    #1;
    check("fl_rdy0", 32'(req_ready), 0);
    @(posedge clk); #1;
    check("fl_drst1", 32'(dut_rst), 1);
    check("fl_rdy1", 32'(req_ready), 0);
    @(posedge clk); #1;
    check("fl_drst0", 32'(dut_rst), 0);
    check("fl_cnt", 32'(step_cnt), 0);
    check("fl_rdy2", 32'(req_ready), 0);
    @(posedge clk); #1;
    check("fl_again", 32'(dut_rst), 1);
    cfg_flush = 1'b0;
    @(posedge clk); #1;
    check("fl_end", 32'(dut_rst), 0);
    check("fl_rdy3", 32'(req_ready), 1);
    model_s = 0;
    model_cnt = 0;
    txn(2'b01, 11'h155, 11'h0, 0);

    // random traffic, drives step_cnt into saturation
    for (int i = 0; i < 20; i++)
      txn(2'($urandom_range(1, 3)), 11'($urandom_range(0, 2047)),
          11'($urandom_range(0, 2047)), int'($urandom_range(0, 2)));
    check("sat_cnt", 32'(step_cnt), 15);
    check("en_cycles", 32'(en_cnt), 32'(model_total));

    // reset in the middle of STEP
    req_valid = 2'b01;
    req_vec = {11'h0, 11'h3AB};
    #1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    check("mid_en1", 32'(dut_clk_en), 1);
    rst = 1'b1;
    #1;
    check("mid_rv", 32'(resp_valid), 0);
    check("mid_en", 32'(dut_clk_en), 0);
    check("mid_x", 32'(dut_x), 0);
    check("mid_drst", 32'(dut_rst), 1);
    check("mid_cnt", 32'(step_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_s = 0;
    model_cnt = 0;
    rr_last = 1'b1;
    check("mid_drst2", 32'(dut_rst), 1);
    @(posedge clk); #1;
    check("mid_drst3", 32'(dut_rst), 0);
    check("mid_fsm", 32'(fsm_s), 0);
    txn(2'b11, 11'h600, 11'h7FF, 0);
    check("post_y", 32'(resp_y), 32'h000A02);
    check("post_cnt", 32'(step_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
